// File: rtl/int_controller.sv
// rtl/int_controller.sv - prioritised edge-latched interrupt controller for the 8-bit core
module int_controller #(
  parameter int          N_SRC     = 4,
  parameter logic [7:0]  VEC_RST   = 8'hF0,
  parameter int          VEC_SHIFT = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             int_ret,
  input  logic             cfg_w_en,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_w_data,
  output logic [7:0]       cfg_r_data,
  output logic             int_req,
  output logic [7:0]       int_vec,
  output logic [7:0]       int_en,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [N_SRC-1:0]   enable_q, pending_q, pending_n, irq_prev_q;
  logic [N_SRC-1:0]   eligible, rise, grant_mask;
  logic [7:0]         vecbase_q;
  logic               gen_q;
  logic [2:0]         id_q, winner;
  logic               grant;
  logic [7:0]         rd_val;

  logic wr_enable, wr_pending, wr_vecbase, wr_ctrl;
  assign wr_enable  = cfg_w_en && (cfg_addr == 2'd0);
  assign wr_pending = cfg_w_en && (cfg_addr == 2'd1);
  assign wr_vecbase = cfg_w_en && (cfg_addr == 2'd2);
  assign wr_ctrl    = cfg_w_en && (cfg_addr == 2'd3);

  assign eligible   = pending_q & enable_q;
  assign rise       = irq_src & ~irq_prev_q;
  assign grant_mask = N_SRC'(1) << winner;

  // Request/service state is fully encoded in the state register
  assign int_req = (state_q == ST_REQ);
  assign busy    = (state_q == ST_SERVICE);
  assign int_en  = {7'b0, gen_q};

  // Lowest-indexed eligible source wins
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // Next-state: one request cycle, then hold in service until return-from-interrupt
  always_comb begin
    state_n = state_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gen_q && (|eligible)) begin
          grant   = 1'b1;
          state_n = ST_REQ;
        end
      end
      ST_REQ:     state_n = ST_SERVICE;
      ST_SERVICE: if (int_ret) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Pending update: W1C and grant clear first, then a new edge re-sets the bit
  always_comb begin
    pending_n = pending_q;
    if (wr_pending) pending_n = pending_n & ~cfg_w_data[N_SRC-1:0];
    if (grant)      pending_n = pending_n & ~grant_mask;
    pending_n = pending_n | rise;
  end

  // Register read mux; unimplemented bits read as zero
  always_comb begin
    rd_val = '0;
    case (cfg_addr)
      2'd0: rd_val[N_SRC-1:0] = enable_q;
      2'd1: rd_val[N_SRC-1:0] = pending_q;
      2'd2: rd_val = vecbase_q;
      default: rd_val = {busy, 1'b0, id_q, 2'b00, gen_q};
    endcase
  end

  // State, configuration, pending, vector and read-data registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      enable_q   <= '0;
      pending_q  <= '0;
      vecbase_q  <= VEC_RST;
      gen_q      <= 1'b0;
      id_q       <= '0;
      int_vec    <= '0;
      cfg_r_data <= '0;
      irq_prev_q <= irq_src;
    end else begin
      state_q    <= state_n;
      pending_q  <= pending_n;
      irq_prev_q <= irq_src;
      cfg_r_data <= rd_val;
      if (wr_enable)  enable_q  <= cfg_w_data[N_SRC-1:0];
      if (wr_vecbase) vecbase_q <= cfg_w_data;
      if (wr_ctrl)    gen_q     <= cfg_w_data[0];
      if (grant) begin
        id_q    <= winner;
        int_vec <= vecbase_q + (8'(winner) << VEC_SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - randomized and directed self-checking bench for int_controller
`timescale 1ns/1ps
module tb_int_controller;
  localparam int N = 4;
  localparam int VS = 2;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] irq_src = '0;
  logic         int_ret = 1'b0;
  logic         cfg_w_en = 1'b0;
  logic [1:0]   cfg_addr = '0;
  logic [7:0]   cfg_w_data = '0;
  logic [7:0]   cfg_r_data, int_vec, int_en;
  logic         int_req, busy;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic [N-1:0] m_en, m_pend, m_prev;
  logic [7:0]   m_vb, m_vec, m_rd;
  logic [2:0]   m_id;
  logic         m_gen, m_req, m_busy;

  int_controller #(.N_SRC(N), .VEC_RST(8'hF0), .VEC_SHIFT(VS)) dut (
    .clock(clock), .reset_n(reset_n), .irq_src(irq_src), .int_ret(int_ret),
    .cfg_w_en(cfg_w_en), .cfg_addr(cfg_addr), .cfg_w_data(cfg_w_data),
    .cfg_r_data(cfg_r_data), .int_req(int_req), .int_vec(int_vec),
    .int_en(int_en), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic model_step();
    logic [7:0]   rd;
    logic [N-1:0] np;
    int           k;
    if (!reset_n) begin
      m_en = '0; m_pend = '0; m_vb = 8'hF0; m_gen = 0; m_id = 0; m_vec = 0;
      m_req = 0; m_busy = 0; m_rd = 0; m_prev = irq_src;
    end else begin
      case (cfg_addr)
        2'd0: rd = {4'b0, m_en};
        2'd1: rd = {4'b0, m_pend};
        2'd2: rd = m_vb;
        default: rd = {m_busy, 1'b0, m_id, 2'b00, m_gen};
      endcase
      np = m_pend;
      if (cfg_w_en && cfg_addr == 2'd1) np = np & ~cfg_w_data[N-1:0];
      if (m_req) begin
        m_req = 0; m_busy = 1;
      end else if (m_busy) begin
        if (int_ret) m_busy = 0;
      end else if (m_gen && (m_pend & m_en) != 0) begin
        k = 0;
        while (!(m_pend[k] && m_en[k])) k++;
        m_id  = 3'(k);
        m_vec = 8'((int'(m_vb) + k * (2 ** VS)) % 256);
        np[k] = 1'b0;
        m_req = 1;
      end
      np = np | (irq_src & ~m_prev);
      m_prev = irq_src;
      m_pend = np;
      if (cfg_w_en && cfg_addr == 2'd0) m_en  = cfg_w_data[N-1:0];
      if (cfg_w_en && cfg_addr == 2'd2) m_vb  = cfg_w_data;
      if (cfg_w_en && cfg_addr == 2'd3) m_gen = cfg_w_data[0];
      m_rd = rd;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_w_en = 1; cfg_addr = a; cfg_w_data = d;
    cycle();
    cfg_w_en = 0;
  endtask

  task automatic pulse_ret();
    int_ret = 1; cycle(); int_ret = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; cycle(); cycle(); reset_n = 1;
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_int_req got %b want 0", int_req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (int_en !== 8'h00) begin n_fail++; $display("FAIL reset_int_en got %h want 00", int_en); end
    n_checks++; if (int_vec !== 8'h00) begin n_fail++; $display("FAIL reset_int_vec got %h want 00", int_vec); end
    n_checks++; if (cfg_r_data !== 8'h00) begin n_fail++; $display("FAIL reset_r_data got %h want 00", cfg_r_data); end
    cfg_addr = 2; cycle();
    n_checks++; if (cfg_r_data !== 8'hF0) begin n_fail++; $display("FAIL reset_vecbase got %h want f0", cfg_r_data); end
  endtask

  task automatic test_single();
    cfg_write(0, 8'h0F); cfg_write(2, 8'h80); cfg_write(3, 8'h01);
    n_checks++; if (int_en !== 8'h01) begin n_fail++; $display("FAIL single_int_en got %h want 01", int_en); end
    irq_src = 4'b0100; cycle();
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL single_early_req got %b want 0", int_req); end
    irq_src = 0; cycle();
    n_checks++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL single_req got %b want 1", int_req); end
    n_checks++; if (int_vec !== 8'h88) begin n_fail++; $display("FAIL single_vec got %h want 88", int_vec); end
    cfg_addr = 1; cycle();
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL single_req_len got %b want 0", int_req); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
    n_checks++; if (cfg_r_data !== 8'h00) begin n_fail++; $display("FAIL single_pending got %h want 00", cfg_r_data); end
    pulse_ret();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_ret_busy got %b want 0", busy); end
  endtask

  task automatic test_simultaneous();
    irq_src = 4'b1010; cycle(); irq_src = 0; cycle();
    n_checks++; if (int_req !== 1'b1 || int_vec !== 8'h84) begin n_fail++; $display("FAIL simul_first got req=%b vec=%h want 1/84", int_req, int_vec); end
    cycle();
    pulse_ret();
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL simul_gap got %b want 0", int_req); end
    cycle();
    n_checks++; if (int_req !== 1'b1 || int_vec !== 8'h8C) begin n_fail++; $display("FAIL simul_second got req=%b vec=%h want 1/8c", int_req, int_vec); end
    cycle(); pulse_ret();
  endtask

  task automatic test_service_edge();
    irq_src = 4'b0100; cycle(); irq_src = 0; cycle(); cycle();
    irq_src = 4'b0001; cycle(); irq_src = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL svc_hold cyc %0d got %b want 0", i, int_req); end
    end
    pulse_ret();
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL svc_after_ret1 got %b want 0", int_req); end
    cycle();
    n_checks++; if (int_req !== 1'b1 || int_vec !== 8'h80) begin n_fail++; $display("FAIL svc_after_ret2 got req=%b vec=%h want 1/80", int_req, int_vec); end
    cycle(); pulse_ret();
  endtask

  task automatic test_masked();
    cfg_write(0, 8'h00);
    irq_src = 4'b0010; cycle(); irq_src = 0;
    cfg_addr = 1; cycle();
    n_checks++; if (cfg_r_data !== 8'h02 || int_req !== 1'b0) begin n_fail++; $display("FAIL mask_pending got rd=%h req=%b want 02/0", cfg_r_data, int_req); end
    cfg_write(0, 8'h02);
    n_checks++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL mask_write_edge got %b want 0", int_req); end
    cycle();
    n_checks++; if (int_req !== 1'b1 || int_vec !== 8'h84) begin n_fail++; $display("FAIL mask_reenable got req=%b vec=%h want 1/84", int_req, int_vec); end
    cycle(); pulse_ret();
    irq_src = 4'b0010; cfg_write(1, 8'h02); irq_src = 0;
    cfg_addr = 1; cycle();
    n_checks++; if (cfg_r_data !== 8'h02 || int_req !== 1'b1) begin n_fail++; $display("FAIL mask_set_wins got rd=%h req=%b want 02/1", cfg_r_data, int_req); end
    cycle(); pulse_ret();
  endtask

  task automatic test_wrap();
    cfg_write(0, 8'h0F); cfg_write(2, 8'hFC);
    irq_src = 4'b0010; cycle(); irq_src = 0; cycle();
    n_checks++; if (int_req !== 1'b1 || int_vec !== 8'h00) begin n_fail++; $display("FAIL wrap_vec got req=%b vec=%h want 1/00", int_req, int_vec); end
    cfg_addr = 3; cycle(); cycle();
    n_checks++; if (cfg_r_data !== 8'h89) begin n_fail++; $display("FAIL wrap_ctrl_read got %h want 89", cfg_r_data); end
  endtask

  task automatic test_reset_mid();
    reset_n = 0; cycle(); reset_n = 1;
    n_checks++; if (busy !== 1'b0 || int_req !== 1'b0 || int_en !== 8'h00) begin n_fail++; $display("FAIL midreset_out got busy=%b req=%b en=%h want 0/0/00", busy, int_req, int_en); end
    cfg_addr = 1; cycle();
    n_checks++; if (cfg_r_data !== 8'h00) begin n_fail++; $display("FAIL midreset_pending got %h want 00", cfg_r_data); end
    cfg_addr = 2; cycle();
    n_checks++; if (cfg_r_data !== 8'hF0) begin n_fail++; $display("FAIL midreset_vecbase got %h want f0", cfg_r_data); end
  endtask

  task automatic test_random();
    cfg_write(0, 8'h0F); cfg_write(3, 8'h01);
    for (int c = 0; c < 600; c++) begin
      irq_src  = N'($urandom);
      int_ret  = ($urandom_range(0, 5) == 0);
      reset_n  = ($urandom_range(0, 150) != 0);
      cfg_addr = 2'($urandom);
      cfg_w_en = ($urandom_range(0, 6) == 0);
      cfg_w_data = 8'($urandom);
      if (cfg_addr == 3 && $urandom_range(0, 3) != 0) cfg_w_data[0] = 1'b1;
      if (cfg_addr == 0 && $urandom_range(0, 1) != 0) cfg_w_data[3:0] = 4'hF;
      cycle();
      n_checks++; if (int_req !== m_req) begin n_fail++; $display("FAIL rand_req cyc %0d got %b want %b", c, int_req, m_req); end
      n_checks++; if (busy !== m_busy) begin n_fail++; $display("FAIL rand_busy cyc %0d got %b want %b", c, busy, m_busy); end
      n_checks++; if (int_vec !== m_vec) begin n_fail++; $display("FAIL rand_vec cyc %0d got %h want %h", c, int_vec, m_vec); end
      n_checks++; if (int_en !== {7'b0, m_gen}) begin n_fail++; $display("FAIL rand_int_en cyc %0d got %h want %h", c, int_en, {7'b0, m_gen}); end
      n_checks++; if (cfg_r_data !== m_rd) begin n_fail++; $display("FAIL rand_rdata cyc %0d got %h want %h", c, cfg_r_data, m_rd); end
    end
    cfg_w_en = 0; int_ret = 0; reset_n = 1; irq_src = 0;
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_simultaneous();
    test_service_edge();
    test_masked();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
